// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses, state codes,
// exception flag bit positions and mstatus update helpers.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] ST_IDLE           = 3'd0;
  localparam logic [2:0] ST_W_MEPC         = 3'd1;
  localparam logic [2:0] ST_W_MCAUSE       = 3'd2;
  localparam logic [2:0] ST_W_MSTATUS      = 3'd3;
  localparam logic [2:0] ST_TRAP_JUMP      = 3'd4;
  localparam logic [2:0] ST_W_MSTATUS_MRET = 3'd5;
  localparam logic [2:0] ST_MRET_JUMP      = 3'd6;

  localparam int unsigned EXC_MRET_BIT  = 0;
  localparam int unsigned EXC_ECALL_BIT = 1;

  // Trap entry: stash MIE into MPIE, then disable interrupts.
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] status,
                                                  input int unsigned mie_bit,
                                                  input int unsigned mpie_bit);
    logic [31:0] res;
    res           = status;
    res[mpie_bit] = status[mie_bit];
    res[mie_bit]  = 1'b0;
    return res;
  endfunction

  // Trap return: restore MIE from MPIE and set MPIE.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] status,
                                                  input int unsigned mie_bit,
                                                  input int unsigned mpie_bit);
    logic [31:0] res;
    res           = status;
    res[mie_bit]  = status[mpie_bit];
    res[mpie_bit] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: writes mepc/mcause/mstatus in a fixed order while holding
// the pipeline, then redirects the PC to mtvec (trap) or mepc (mret).
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter logic [31:0] IRQ_CAUSE   = 32'h8000_0007,
  parameter int unsigned MIE_BIT     = 3,
  parameter int unsigned MPIE_BIT    = 7
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic [31:0] exception_in,
  input  logic [31:0] inst_addr_in,
  input  logic        jump_flag_in,
  input  logic [31:0] jump_addr_in,
  input  logic        irq_in,
  input  logic [31:0] csr_mtvec_in,
  input  logic [31:0] csr_mepc_in,
  input  logic [31:0] csr_mstatus_in,
  output logic        csr_we_out,
  output logic [11:0] csr_waddr_out,
  output logic [31:0] csr_wdata_out,
  output logic        stallreq_out,
  output logic        int_assert_out,
  output logic [31:0] int_addr_out
);

  logic [2:0]  state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;

  logic in_idle;
  logic take_ecall, take_mret, take_irq;
  logic unused_exc;

  assign unused_exc = ^exception_in[31:2];

  assign in_idle = (state_q == ST_IDLE);

  // Priority ecall > mret > irq; a trigger seen alongside reset is dropped.
  always_comb begin
    take_ecall = in_idle & ~reset_in & exception_in[EXC_ECALL_BIT];
    take_mret  = in_idle & ~reset_in & exception_in[EXC_MRET_BIT] & ~take_ecall;
    take_irq   = in_idle & ~reset_in & irq_in & csr_mstatus_in[MIE_BIT] &
                 ~take_ecall & ~take_mret;
  end

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (take_ecall) begin
          epc_d   = inst_addr_in;
          cause_d = ECALL_CAUSE;
          state_d = ST_W_MEPC;
        end else if (take_mret) begin
          state_d = ST_W_MSTATUS_MRET;
        end else if (take_irq) begin
          // A redirect in flight means the interrupted instruction is the jump target.
          epc_d   = jump_flag_in ? jump_addr_in : inst_addr_in;
          cause_d = IRQ_CAUSE;
          state_d = ST_W_MEPC;
        end
      end
      ST_W_MEPC:         state_d = ST_W_MCAUSE;
      ST_W_MCAUSE:       state_d = ST_W_MSTATUS;
      ST_W_MSTATUS:      state_d = ST_TRAP_JUMP;
      ST_TRAP_JUMP:      state_d = ST_IDLE;
      ST_W_MSTATUS_MRET: state_d = ST_MRET_JUMP;
      ST_MRET_JUMP:      state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      epc_q   <= 32'd0;
      cause_q <= 32'd0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    csr_we_out     = 1'b0;
    csr_waddr_out  = 12'd0;
    csr_wdata_out  = 32'd0;
    int_assert_out = 1'b0;
    int_addr_out   = 32'd0;
    stallreq_out   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        stallreq_out = take_ecall | take_mret | take_irq;
      end
      ST_W_MEPC: begin
        csr_we_out    = 1'b1;
        csr_waddr_out = CSR_MEPC;
        csr_wdata_out = epc_q;
      end
      ST_W_MCAUSE: begin
        csr_we_out    = 1'b1;
        csr_waddr_out = CSR_MCAUSE;
        csr_wdata_out = cause_q;
      end
      ST_W_MSTATUS: begin
        csr_we_out    = 1'b1;
        csr_waddr_out = CSR_MSTATUS;
        csr_wdata_out = mstatus_on_trap(csr_mstatus_in, MIE_BIT, MPIE_BIT);
      end
      ST_TRAP_JUMP: begin
        int_assert_out = 1'b1;
        int_addr_out   = csr_mtvec_in;
      end
      ST_W_MSTATUS_MRET: begin
        csr_we_out    = 1'b1;
        csr_waddr_out = CSR_MSTATUS;
        csr_wdata_out = mstatus_on_mret(csr_mstatus_in, MIE_BIT, MPIE_BIT);
      end
      ST_MRET_JUMP: begin
        int_assert_out = 1'b1;
        int_addr_out   = csr_mepc_in;
      end
      default: begin
        stallreq_out = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized bench for trap_ctrl with a per-cycle expectation queue and a tiny CSR file.
module tb_trap_ctrl;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [31:0] exception_in;
  logic [31:0] inst_addr_in;
  logic        jump_flag_in;
  logic [31:0] jump_addr_in;
  logic        irq_in;
  logic [31:0] csr_mtvec_in;
  logic [31:0] csr_mepc_in;
  logic [31:0] csr_mstatus_in;
  logic        csr_we_out;
  logic [11:0] csr_waddr_out;
  logic [31:0] csr_wdata_out;
  logic        stallreq_out;
  logic        int_assert_out;
  logic [31:0] int_addr_out;

  trap_ctrl dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .exception_in   (exception_in),
    .inst_addr_in   (inst_addr_in),
    .jump_flag_in   (jump_flag_in),
    .jump_addr_in   (jump_addr_in),
    .irq_in         (irq_in),
    .csr_mtvec_in   (csr_mtvec_in),
    .csr_mepc_in    (csr_mepc_in),
    .csr_mstatus_in (csr_mstatus_in),
    .csr_we_out     (csr_we_out),
    .csr_waddr_out  (csr_waddr_out),
    .csr_wdata_out  (csr_wdata_out),
    .stallreq_out   (stallreq_out),
    .int_assert_out (int_assert_out),
    .int_addr_out   (int_addr_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        stall;
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        ia;
    logic [31:0] iaddr;
  } exp_t;

  exp_t exp_q[$];

  // CSR file as the core's csr_reg would hold it
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [11:0] addr, input logic [31:0] data,
                              input logic ia, input logic [31:0] iaddr);
    exp_t e;
    e.stall = 1'b1;
    e.we    = we;
    e.addr  = addr;
    e.data  = data;
    e.ia    = ia;
    e.iaddr = iaddr;
    return e;
  endfunction

  // One clock cycle: drive at negedge, predict, check just before posedge.
  task automatic step(input logic [31:0] exc, input logic irq, input logic jf,
                      input logic [31:0] ja, input logic [31:0] ia, input logic rst);
    exp_t        e;
    logic [31:0] st;
    @(negedge clk_in);
    reset_in       = rst;
    exception_in   = exc;
    irq_in         = irq;
    jump_flag_in   = jf;
    jump_addr_in   = ja;
    inst_addr_in   = ia;
    csr_mstatus_in = m_mstatus;
    csr_mtvec_in   = m_mtvec;
    csr_mepc_in    = m_mepc;
    if (exp_q.size() == 0 && !rst) begin
      if (exc[1] || (!exc[0] && irq && m_mstatus[3])) begin
        st    = m_mstatus;
        st[7] = m_mstatus[3];
        st[3] = 1'b0;
        exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 12'h341, exc[1] ? ia : (jf ? ja : ia), 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 12'h342, exc[1] ? 32'd11 : 32'h8000_0007, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 12'h300, st, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, m_mtvec));
      end else if (exc[0]) begin
        st    = m_mstatus;
        st[3] = m_mstatus[7];
        st[7] = 1'b1;
        exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 12'h300, st, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b0, 12'h0, 32'h0, 1'b1, m_mepc));
      end
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    #1;
    check_eq("stallreq", {31'd0, stallreq_out}, {31'd0, e.stall});
    check_eq("csr_we", {31'd0, csr_we_out}, {31'd0, e.we});
    check_eq("csr_waddr", {20'd0, csr_waddr_out}, {20'd0, e.addr});
    check_eq("csr_wdata", csr_wdata_out, e.data);
    check_eq("int_assert", {31'd0, int_assert_out}, {31'd0, e.ia});
    check_eq("int_addr", int_addr_out, e.iaddr);
    if (e.we) begin
      case (e.addr)
        12'h300: m_mstatus = e.data;
        12'h341: m_mepc    = e.data;
        12'h342: m_mcause  = e.data;
        default: ;
      endcase
    end
    if (rst) exp_q.delete();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] exc;
    int          r;
    m_mstatus      = 32'h8;
    m_mtvec        = 32'h400;
    m_mepc         = 32'h0;
    m_mcause       = 32'h0;
    reset_in       = 1'b1;
    exception_in   = 32'h0;
    inst_addr_in   = 32'h0;
    jump_flag_in   = 1'b0;
    jump_addr_in   = 32'h0;
    irq_in         = 1'b0;
    csr_mtvec_in   = m_mtvec;
    csr_mepc_in    = m_mepc;
    csr_mstatus_in = m_mstatus;
    @(posedge clk_in);
    step(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle_cycles(2);

    // ecall at 0x100 with MIE set
    step(32'h2, 1'b0, 1'b0, 32'h0, 32'h100, 1'b0);
    idle_cycles(5);

    // mret with mstatus=0x80, mepc=0x104
    m_mstatus = 32'h80;
    m_mepc    = 32'h104;
    step(32'h1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle_cycles(3);

    // masked irq, then unmasked
    m_mstatus = 32'h0;
    for (int i = 0; i < 10; i++) step(32'h0, 1'b1, 1'b0, 32'h0, 32'h10c, 1'b0);
    m_mstatus = 32'h8;
    for (int i = 0; i < 6; i++) step(32'h0, 1'b1, 1'b0, 32'h0, 32'h10c, 1'b0);
    idle_cycles(2);

    // irq during a jump: mepc takes the jump target
    m_mstatus = 32'h8;
    step(32'h0, 1'b1, 1'b1, 32'h200, 32'h108, 1'b0);
    idle_cycles(5);

    // ecall + irq together, irq held afterwards with MIE now clear
    m_mstatus = 32'h8;
    for (int i = 0; i < 10; i++) step(32'h2, 1'b1, 1'b0, 32'h0, 32'h120, 1'b0);
    for (int i = 0; i < 5; i++) step(32'h0, 1'b1, 1'b0, 32'h0, 32'h124, 1'b0);
    check_eq("mcause_after_ecall_irq", m_mcause, 32'd11);

    // reset while writing mcause
    m_mstatus = 32'h8;
    step(32'h2, 1'b0, 1'b0, 32'h0, 32'h130, 1'b0);
    step(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle_cycles(4);
    check_eq("mstatus_untouched_after_reset", m_mstatus, 32'h8);

    // randomized traffic including back-to-back triggers
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && $urandom_range(0, 7) == 0) begin
        m_mstatus = $urandom;
        m_mtvec   = $urandom;
        m_mepc    = $urandom;
      end
      r   = $urandom_range(0, 15);
      exc = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hffff_fffc) : 32'h0;
      if (r == 0) exc[1] = 1'b1;
      else if (r == 1) exc[0] = 1'b1;
      else if (r == 2) exc[1:0] = 2'b11;
      step(exc, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
           $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
